atm_keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad, debounces one key at a time and converts it into
//  the single-cycle strobes consumed by the ATM controller: DIGITO/DIGITO_STB for
//  PIN digits, TIPO_TRANS/TIPO_STB for transaction selection, CANCEL_STB for '*'.

---
 rtl/atm_keypad_scanner.sv | 183 ++++++++++++++++++
 tb/tb_atm_keypad_scanner.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_keypad_scanner.sv
// 4x4 keypad scanner: rotates column drive, debounces one key at a time and
// emits single-cycle digit / transaction-type / cancel strobes.
module atm_keypad_scanner #(
  parameter int SCAN_DIV   = 4,
  parameter int DEB_CYCLES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] KP_ROW,
  output logic [3:0] KP_COL,
  output logic [3:0] DIGITO,
  output logic       DIGITO_STB,
  output logic       TIPO_TRANS,
  output logic       TIPO_STB,
  output logic       CANCEL_STB,
  output logic       KEY_BUSY
);

  // state       | meaning
  // ST_SCAN     | rotate column drive, sample rows at end of each slot
  // ST_DEBOUNCE | key latched, counting stable cycles before strobing
  // ST_HELD     | strobe issued, waiting for all rows high
  // ST_RELEASE  | counting stable all-high cycles before resuming scan
  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD, ST_RELEASE} state_e;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       row_s1_q, row_s2_q;
  logic [1:0]       col_q, col_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [3:0]       pat_q, pat_d;
  logic [1:0]       key_row_q, key_row_d;
  logic [3:0]       digito_q, digito_d;
  logic             tipo_q, tipo_d;
  logic             digit_stb_q, digit_stb_d;
  logic             tipo_stb_q, tipo_stb_d;
  logic             cancel_stb_q, cancel_stb_d;

  logic [3:0] rows_low;
  logic       one_low;
  logic [1:0] row_idx;
  logic       fire;

  assign rows_low = ~row_s2_q;
  assign one_low  = (rows_low != 4'd0) && ((rows_low & (rows_low - 4'd1)) == 4'd0);

  always_comb begin
    row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (rows_low[i]) row_idx = 2'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    div_d        = div_q;
    deb_d        = deb_q;
    pat_d        = pat_q;
    key_row_d    = key_row_q;
    fire         = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (one_low) begin
            pat_d     = row_s2_q;
            key_row_d = row_idx;
            deb_d     = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (row_s2_q != pat_q) begin
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          div_d   = '0;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = ST_HELD;
          deb_d   = '0;
          fire    = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (row_s2_q == 4'hF) begin
          state_d = ST_RELEASE;
          deb_d   = '0;
        end
      end
      ST_RELEASE: begin
        if (row_s2_q != 4'hF) begin
          state_d = ST_HELD;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          div_d   = '0;
          deb_d   = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // Key decode at debounce completion; C, D and '#' fall through silently.
  always_comb begin
    digito_d     = digito_q;
    tipo_d       = tipo_q;
    digit_stb_d  = 1'b0;
    tipo_stb_d   = 1'b0;
    cancel_stb_d = 1'b0;
    if (fire) begin
      if (key_row_q != 2'd3 && col_q != 2'd3) begin
        digit_stb_d = 1'b1;
        digito_d    = {2'b00, key_row_q} * 4'd3 + {2'b00, col_q} + 4'd1;
      end else if (key_row_q == 2'd3 && col_q == 2'd1) begin
        digit_stb_d = 1'b1;
        digito_d    = 4'd0;
      end else if (key_row_q == 2'd3 && col_q == 2'd0) begin
        cancel_stb_d = 1'b1;
      end else if (col_q == 2'd3 && key_row_q[1] == 1'b0) begin
        tipo_stb_d = 1'b1;
        tipo_d     = key_row_q[0];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      row_s1_q     <= 4'hF;
      row_s2_q     <= 4'hF;
      state_q      <= ST_SCAN;
      col_q        <= 2'd0;
      div_q        <= '0;
      deb_q        <= '0;
      pat_q        <= 4'hF;
      key_row_q    <= 2'd0;
      digito_q     <= 4'd0;
      tipo_q       <= 1'b0;
      digit_stb_q  <= 1'b0;
      tipo_stb_q   <= 1'b0;
      cancel_stb_q <= 1'b0;
    end else begin
      row_s1_q     <= KP_ROW;
      row_s2_q     <= row_s1_q;
      state_q      <= state_d;
      col_q        <= col_d;
      div_q        <= div_d;
      deb_q        <= deb_d;
      pat_q        <= pat_d;
      key_row_q    <= key_row_d;
      digito_q     <= digito_d;
      tipo_q       <= tipo_d;
      digit_stb_q  <= digit_stb_d;
      tipo_stb_q   <= tipo_stb_d;
      cancel_stb_q <= cancel_stb_d;
    end
  end

  assign KP_COL     = ~(4'b0001 << col_q);
  assign KEY_BUSY   = (state_q != ST_SCAN);
  assign DIGITO     = digito_q;
  assign DIGITO_STB = digit_stb_q;
  assign TIPO_TRANS = tipo_q;
  assign TIPO_STB   = tipo_stb_q;
  assign CANCEL_STB = cancel_stb_q;

endmodule

// File: tb/tb_atm_keypad_scanner.sv
// Bench for atm_keypad_scanner: a matrix model closes rows through the driven
// column; strobes are checked against a queue of expected key events.
module tb_atm_keypad_scanner;

  logic       Clk;
  logic       Reset;
  logic [3:0] KP_ROW;
  logic [3:0] KP_COL;
  logic [3:0] DIGITO;
  logic       DIGITO_STB;
  logic       TIPO_TRANS;
  logic       TIPO_STB;
  logic       CANCEL_STB;
  logic       KEY_BUSY;

  logic [3:0][3:0] key_dn;  // [row][col]

  int compared   = 0;
  int mismatched = 0;
  int stb_total  = 0;
  logic [5:0] exp_q[$];     // {kind, value}: 0 digit, 1 tipo, 2 cancel

  atm_keypad_scanner #(.SCAN_DIV(4), .DEB_CYCLES(8)) dut (
    .Clk(Clk), .Reset(Reset), .KP_ROW(KP_ROW), .KP_COL(KP_COL),
    .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB), .TIPO_TRANS(TIPO_TRANS),
    .TIPO_STB(TIPO_STB), .CANCEL_STB(CANCEL_STB), .KEY_BUSY(KEY_BUSY)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always_comb begin
    KP_ROW = 4'hF;
    for (int r = 0; r < 4; r++) KP_ROW[r] = ~|(key_dn[r] & ~KP_COL);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic monitor();
    logic [5:0] obs, expv;
    logic [3:0] prev_dig;
    int nstb;
    prev_dig = 4'd0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        prev_dig = DIGITO;
        continue;
      end
      nstb = int'(DIGITO_STB) + int'(TIPO_STB) + int'(CANCEL_STB);
      if (DIGITO !== prev_dig) begin
        compared++;
        if (DIGITO_STB !== 1'b1) begin
          mismatched++;
          $display("FAIL digito_hold: DIGITO changed %0d->%0d without strobe", prev_dig, DIGITO);
        end
      end
      prev_dig = DIGITO;
      if (nstb > 0) begin
        stb_total++;
        compared++;
        if (nstb > 1) begin
          mismatched++;
          $display("FAIL one_strobe: %0d strobes high, required 1", nstb);
        end
        if (DIGITO_STB) obs = {2'd0, DIGITO};
        else if (TIPO_STB) obs = {2'd1, 3'b000, TIPO_TRANS};
        else obs = {2'd2, 4'd0};
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_strobe: got kind %0d val %0d, expected none", obs[5:4], obs[3:0]);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            mismatched++;
            $display("FAIL strobe_event: got kind %0d val %0d, expected kind %0d val %0d",
                     obs[5:4], obs[3:0], expv[5:4], expv[3:0]);
          end
        end
      end
    end
  endtask

  task automatic wait_busy(input logic lvl, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge Clk);
      if (KEY_BUSY === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_stb(input int s0, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge Clk);
      if (stb_total != s0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Press, hold and release one key; expect_stb=0 means it must stay silent.
  task automatic press_key(input int row, input int col, input bit expect_stb, input logic [5:0] ev);
    int s0;
    bit ok;
    s0 = stb_total;
    if (expect_stb) exp_q.push_back(ev);
    key_dn[row][col] = 1'b1;
    wait_busy(1'b1, 40, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL detect_r%0dc%0d: KEY_BUSY=%b, required 1 within 40 cycles", row, col, KEY_BUSY);
    end
    if (expect_stb) begin
      wait_stb(s0, 40, ok);
      compared++;
      if (!ok) begin
        mismatched++;
        $display("FAIL strobe_r%0dc%0d: no strobe within 40 cycles", row, col);
      end
      cyc(10);
    end else begin
      cyc(40);
    end
    compared++;
    if (stb_total - s0 != int'(expect_stb)) begin
      mismatched++;
      $display("FAIL strobe_count_r%0dc%0d: got %0d, required %0d", row, col, stb_total - s0, int'(expect_stb));
    end
    key_dn[row][col] = 1'b0;
    wait_busy(1'b0, 40, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL release_r%0dc%0d: KEY_BUSY=%b, required 0 within 40 cycles", row, col, KEY_BUSY);
    end
    cyc(3);
  endtask

  task automatic test_reset();
    Reset  = 1'b1;
    key_dn = '0;
    cyc(3);
    compared++;
    if ({KP_COL, DIGITO, TIPO_TRANS, DIGITO_STB, TIPO_STB, CANCEL_STB, KEY_BUSY} !== {4'b1110, 4'd0, 5'b0}) begin
      mismatched++;
      $display("FAIL reset_vals: col=%b dig=%0d tipo=%b stb=%b%b%b busy=%b", KP_COL, DIGITO,
               TIPO_TRANS, DIGITO_STB, TIPO_STB, CANCEL_STB, KEY_BUSY);
    end
    Reset = 1'b0;
    cyc(1);
    compared++;
    if (KP_COL !== 4'b1110 || KEY_BUSY !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: col=%b busy=%b, required 1110/0", KP_COL, KEY_BUSY);
    end
  endtask

  task automatic test_single_press();
    int s0, bad;
    bit ok;
    s0 = stb_total;
    exp_q.push_back({2'd0, 4'd6});
    key_dn[1][2] = 1'b1;
    wait_busy(1'b1, 40, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL busy_rise: KEY_BUSY=%b, required 1", KEY_BUSY);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (KEY_BUSY !== 1'b1) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL busy_hold: %0d cycles low, required 0", bad);
    end
    compared++;
    if (stb_total - s0 != 1 || DIGITO !== 4'd6) begin
      mismatched++;
      $display("FAIL press6: strobes=%0d DIGITO=%0d, required 1/6", stb_total - s0, DIGITO);
    end
    key_dn[1][2] = 1'b0;
    cyc(4);
    compared++;
    if (KEY_BUSY !== 1'b1) begin
      mismatched++;
      $display("FAIL busy_release_deb: KEY_BUSY=%b, required 1", KEY_BUSY);
    end
    wait_busy(1'b0, 30, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL busy_fall: KEY_BUSY=%b, required 0", KEY_BUSY);
    end
    cyc(3);
  endtask

  task automatic test_pin_sequence();
    press_key(1, 2, 1'b1, {2'd0, 4'd6});
    press_key(0, 0, 1'b1, {2'd0, 4'd1});
    press_key(2, 2, 1'b1, {2'd0, 4'd9});
    press_key(1, 1, 1'b1, {2'd0, 4'd5});
    compared++;
    if (DIGITO !== 4'd5) begin
      mismatched++;
      $display("FAIL pin_last: DIGITO=%0d, required 5", DIGITO);
    end
  endtask

  task automatic test_function_keys();
    press_key(0, 3, 1'b1, {2'd1, 4'd0});
    compared++;
    if (TIPO_TRANS !== 1'b0) begin
      mismatched++;
      $display("FAIL tipo_a: TIPO_TRANS=%b, required 0", TIPO_TRANS);
    end
    press_key(1, 3, 1'b1, {2'd1, 4'd1});
    compared++;
    if (TIPO_TRANS !== 1'b1) begin
      mismatched++;
      $display("FAIL tipo_b: TIPO_TRANS=%b, required 1", TIPO_TRANS);
    end
    press_key(3, 0, 1'b1, {2'd2, 4'd0});
    press_key(3, 2, 1'b0, 6'd0);
    press_key(3, 1, 1'b1, {2'd0, 4'd0});
    compared++;
    if (TIPO_TRANS !== 1'b1 || DIGITO !== 4'd0) begin
      mismatched++;
      $display("FAIL fkey_hold: TIPO_TRANS=%b DIGITO=%0d, required 1/0", TIPO_TRANS, DIGITO);
    end
  endtask

  task automatic test_bounce();
    int s0, guard;
    bit ok;
    s0 = stb_total;
    exp_q.push_back({2'd0, 4'd5});
    guard = 0;
    while (KP_COL !== 4'b1101 && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    for (int i = 0; i < 3; i++) begin
      key_dn[1][1] = 1'b1;
      cyc(2);
      key_dn[1][1] = 1'b0;
      cyc(2);
    end
    key_dn[1][1] = 1'b1;
    wait_stb(s0, 60, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL bounce_strobe: no strobe within 60 cycles");
    end
    cyc(20);
    compared++;
    if (stb_total - s0 != 1 || DIGITO !== 4'd5) begin
      mismatched++;
      $display("FAIL bounce_count: strobes=%0d DIGITO=%0d, required 1/5", stb_total - s0, DIGITO);
    end
    key_dn[1][1] = 1'b0;
    wait_busy(1'b0, 40, ok);
    cyc(3);
    s0 = stb_total;
    guard = 0;
    while (KP_COL !== 4'b1101 && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    key_dn[1][1] = 1'b1;
    cyc(4);
    key_dn[1][1] = 1'b0;
    cyc(60);
    compared++;
    if (stb_total != s0 || KEY_BUSY !== 1'b0) begin
      mismatched++;
      $display("FAIL glitch: strobes=%0d busy=%b, required 0/0", stb_total - s0, KEY_BUSY);
    end
  endtask

  task automatic test_multi_key();
    int s0, run, trans, bad_busy;
    logic [3:0] prev;
    s0 = stb_total;
    key_dn[0][0] = 1'b1;
    key_dn[1][0] = 1'b1;
    prev = KP_COL;
    run = -1;
    trans = 0;
    bad_busy = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge Clk);
      if (KEY_BUSY !== 1'b0) bad_busy++;
      if (run >= 0) run++;
      if (KP_COL !== prev) begin
        trans++;
        compared++;
        if (KP_COL !== {prev[2:0], prev[3]} || (run >= 0 && run != 4)) begin
          mismatched++;
          $display("FAIL col_rotate: %b->%b after %0d cycles, required %b after 4",
                   prev, KP_COL, run, {prev[2:0], prev[3]});
        end
        run = 0;
        prev = KP_COL;
      end
    end
    compared++;
    if (trans < 16 || bad_busy != 0 || stb_total != s0) begin
      mismatched++;
      $display("FAIL multi_key: transitions=%0d busy_cycles=%0d strobes=%0d, required >=16/0/0",
               trans, bad_busy, stb_total - s0);
    end
    key_dn[0][0] = 1'b0;
    key_dn[1][0] = 1'b0;
    cyc(5);
  endtask

  task automatic test_reset_mid_hold();
    int s0;
    bit ok;
    s0 = stb_total;
    exp_q.push_back({2'd0, 4'd9});
    key_dn[2][2] = 1'b1;
    wait_stb(s0, 60, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL rst_pre_strobe: no strobe within 60 cycles");
    end
    cyc(10);
    Reset = 1'b1;
    cyc(1);
    compared++;
    if ({KP_COL, DIGITO, TIPO_TRANS, DIGITO_STB, TIPO_STB, CANCEL_STB, KEY_BUSY} !== {4'b1110, 4'd0, 5'b0}) begin
      mismatched++;
      $display("FAIL rst_mid_vals: col=%b dig=%0d tipo=%b stb=%b%b%b busy=%b", KP_COL, DIGITO,
               TIPO_TRANS, DIGITO_STB, TIPO_STB, CANCEL_STB, KEY_BUSY);
    end
    cyc(3);
    s0 = stb_total;
    exp_q.push_back({2'd0, 4'd9});
    Reset = 1'b0;
    wait_stb(s0, 60, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL rst_redetect: no strobe within 60 cycles");
    end
    cyc(30);
    compared++;
    if (stb_total - s0 != 1 || DIGITO !== 4'd9) begin
      mismatched++;
      $display("FAIL rst_post: strobes=%0d DIGITO=%0d, required 1/9", stb_total - s0, DIGITO);
    end
    key_dn[2][2] = 1'b0;
    wait_busy(1'b0, 40, ok);
    cyc(5);
  endtask

  initial begin
    Reset  = 1'b1;
    key_dn = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_press();
    test_pin_sequence();
    test_function_keys();
    test_bounce();
    test_multi_key();
    test_reset_mid_hold();
    cyc(20);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d expected events left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
